icache_dm: RTL and testbench



---
 rtl/icache_dm.sv | 153 +++++++++++++++
 tb/tb_icache_dm.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with word-wide miss refill and flush.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_CNT_EN.
module icache_dm #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned NUM_LINES  = 64,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic              pc_valid,
  input  logic              flush,
  output logic              icache_r,
  output logic [31:0]       instruction,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              busy
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int unsigned WORD_W = $clog2(LINE_WORDS);
  localparam int unsigned OFF_W  = WORD_W + 2;
  localparam int unsigned IDX_W  = $clog2(NUM_LINES);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned LINE_W = ADDR_W - OFF_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    FILL   = 2'd2
  } state_t;

  state_t                  state_q;
  logic [NUM_LINES-1:0]    valid_q;
  logic [LINE_W-1:0]       line_q;
  logic [WORD_W-1:0]       cnt_q;
  logic                    abort_q;

  logic [TAG_W-1:0]        tag_mem  [NUM_LINES];
  logic [31:0]             data_mem [NUM_LINES*LINE_WORDS];

  logic [TAG_W-1:0]        pc_tag;
  logic [IDX_W-1:0]        pc_idx;
  logic [WORD_W-1:0]       pc_word;
  logic [TAG_W-1:0]        line_tag;
  logic [IDX_W-1:0]        line_idx;
  logic                    lookup_hit;
  logic                    start_refill;
  logic                    unused_pc_lsb;

  assign pc_tag        = pc[ADDR_W-1 -: TAG_W];
  assign pc_idx        = pc[OFF_W +: IDX_W];
  assign pc_word       = pc[2 +: WORD_W];
  assign line_tag      = line_q[LINE_W-1 -: TAG_W];
  assign line_idx      = line_q[IDX_W-1:0];
  assign unused_pc_lsb = ^pc[1:0];

  assign lookup_hit   = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);
  assign start_refill = (state_q == IDLE) && pc_valid && !flush && !lookup_hit;

  // Zero-latency lookup; the fetch stage sees the hit in the request cycle.
  always_comb begin
    icache_r    = 1'b0;
    instruction = 32'd0;
    if (pc_valid && (state_q == IDLE) && lookup_hit && !flush) begin
      icache_r    = 1'b1;
      instruction = data_mem[{pc_idx, pc_word}];
    end
  end

  // Refill controller: one outstanding word request, abortable by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      valid_q  <= '0;
      line_q   <= '0;
      cnt_q    <= '0;
      abort_q  <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      busy     <= 1'b0;
    end else begin
      if (flush) valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (start_refill) begin
            state_q  <= REFILL;
            line_q   <= pc[ADDR_W-1:OFF_W];
            cnt_q    <= '0;
            abort_q  <= 1'b0;
            mem_req  <= 1'b1;
            mem_addr <= {pc[ADDR_W-1:OFF_W], WORD_W'(0), 2'b00};
            busy     <= 1'b1;
          end
        end
        REFILL: begin
          if (flush) abort_q <= 1'b1;
          if (mem_ack) begin
            cnt_q <= cnt_q + WORD_W'(1);
            if (abort_q || flush) begin
              // Let the in-flight word finish, then drop the line entirely.
              state_q <= IDLE;
              abort_q <= 1'b0;
              mem_req <= 1'b0;
              busy    <= 1'b0;
            end else if (cnt_q == WORD_W'(LINE_WORDS-1)) begin
              state_q <= FILL;
              mem_req <= 1'b0;
            end else begin
              mem_addr <= {line_q, cnt_q + WORD_W'(1), 2'b00};
            end
          end
        end
        FILL: begin
          state_q <= IDLE;
          busy    <= 1'b0;
          if (!flush) valid_q[line_idx] <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data storage carry no reset; valid bits gate every read.
  always_ff @(posedge clk) begin
    if ((state_q == REFILL) && mem_ack) data_mem[{line_idx, cnt_q}] <= mem_rdata;
    if ((state_q == FILL) && !flush) tag_mem[line_idx] <= line_tag;
  end

`ifdef ICACHE_PERF_CNT_EN
  // Free-running counters, untouched by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      if (icache_r) hit_count <= hit_count + 32'd1;
      if (start_refill) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: vector table for hits, scoreboard of expected bus addresses.
module tb_icache_dm;

  localparam int unsigned LW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] pc;
  logic        pc_valid;
  logic        flush;
  logic        icache_r;
  logic [31:0] instruction;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  icache_dm dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .flush       (flush),
    .icache_r    (icache_r),
    .instruction (instruction),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .busy        (busy)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_count   (hit_count),
    .miss_count  (miss_count)
`endif
  );

  typedef struct {
    logic [63:0] pc;
    logic        pcv;
    logic        exp_r;
    logic [31:0] exp_i;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Backing memory contents: line 0x1000 holds 0xA0..0xA3.
  function automatic logic [31:0] mem_data(input logic [63:0] a);
    logic [31:0] a32;
    logic [31:0] base;
    a32  = a[31:0];
    base = {a32[31:4], 4'h0};
    return ((base - 32'h1000) << 4) + 32'hA0 + {30'd0, a32[3:2]};
  endfunction

  task automatic push_line(input logic [63:0] a);
    logic [63:0] base;
    base = a & ~64'(LW*4-1);
    for (int w = 0; w < int'(LW); w++) sb.push_back(base + 64'(4*w));
  endtask

  task automatic start_miss(input logic [63:0] a);
    next();
    pc = a; pc_valid = 1'b1; flush = 1'b0;
    #2;
    chk("miss_r", 64'(icache_r), 64'd0);
    chk("miss_instr", 64'(instruction), 64'd0);
    push_line(a);
  endtask

  task automatic wait_req(output logic [63:0] exp, output bit ok);
    int n = 0;
    exp = '0;
    while (!mem_req && n < 16) begin
      next(); #2; n++;
    end
    ok = mem_req;
    if (!ok) begin
      chk("req_timeout", 64'd0, 64'd1);
    end else if (sb.size() == 0) begin
      chk("sb_underflow", 64'd0, 64'd1);
      ok = 1'b0;
    end else begin
      exp = sb.pop_front();
      chk("mem_addr", mem_addr, exp);
      chk("refill_busy", 64'(busy), 64'd1);
    end
  endtask

  task automatic ack_word(input logic [63:0] a);
    next(); mem_ack = 1'b1; mem_rdata = mem_data(a);
    next(); mem_ack = 1'b0; mem_rdata = '0;
    #2;
  endtask

  task automatic serve_line(input int dly, input logic [63:0] hit_pc);
    logic [63:0] e;
    bit ok;
    for (int w = 0; w < int'(LW); w++) begin
      wait_req(e, ok);
      if (!ok) return;
      for (int d = 0; d < dly; d++) begin
        next(); #2;
        chk("req_hold", 64'(mem_req), 64'd1);
        chk("addr_hold", mem_addr, e);
      end
      ack_word(e);
    end
    chk("req_drop", 64'(mem_req), 64'd0);
    chk("fill_busy", 64'(busy), 64'd1);
    next(); pc = hit_pc; pc_valid = 1'b1;
    #2;
    chk("hit_r", 64'(icache_r), 64'd1);
    chk("hit_instr", 64'(instruction), 64'(mem_data(hit_pc)));
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [63:0] e;
    bit ok;

    rst_n = 1'b0; pc = '0; pc_valid = 1'b0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    vt[0] = '{64'h1000, 1'b1, 1'b1, 32'hA0};
    vt[1] = '{64'h1004, 1'b1, 1'b1, 32'hA1};
    vt[2] = '{64'h1008, 1'b1, 1'b1, 32'hA2};
    vt[3] = '{64'h100C, 1'b1, 1'b1, 32'hA3};
    vt[4] = '{64'h100B, 1'b1, 1'b1, 32'hA2};
    vt[5] = '{64'h1008, 1'b0, 1'b0, 32'h0};

    // Reset state
    next(); next(); #2;
    chk("rst_r", 64'(icache_r), 64'd0);
    chk("rst_instr", 64'(instruction), 64'd0);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    next(); rst_n = 1'b1;

    // Stray ack while idle
    next(); mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    next(); mem_ack = 1'b0; #2;
    chk("stray_ack_req", 64'(mem_req), 64'd0);
    chk("stray_ack_busy", 64'(busy), 64'd0);

    // Cold miss, then two more hit cycles
    start_miss(64'h1000);
    serve_line(0, 64'h1000);
    next(); pc = 64'h1004; #2;
    chk("hit2", 64'(instruction), 64'hA1);
    next(); pc = 64'h1008; #2;
    chk("hit3", 64'(instruction), 64'hA2);
    next(); pc_valid = 1'b0; #2;
`ifdef ICACHE_PERF_CNT_EN
    chk("miss_count", 64'(miss_count), 64'd1);
    chk("hit_count", 64'(hit_count), 64'd3);
`endif

    // Hits within the filled line
    for (int i = 0; i < 6; i++) begin
      next(); pc = vt[i].pc; pc_valid = vt[i].pcv; #2;
      chk($sformatf("vec%0d_r", i), 64'(icache_r), 64'(vt[i].exp_r));
      chk($sformatf("vec%0d_instr", i), 64'(instruction), 64'(vt[i].exp_i));
      chk($sformatf("vec%0d_req", i), 64'(mem_req), 64'd0);
    end

    // Conflict on the same index
    start_miss(64'h1400);
    serve_line(0, 64'h1400);
    start_miss(64'h1000);
    serve_line(1, 64'h1000);

    // Flush while idle
    next(); pc = 64'h1000; pc_valid = 1'b1; flush = 1'b1; #2;
    chk("flush_idle_r", 64'(icache_r), 64'd0);
    chk("flush_idle_instr", 64'(instruction), 64'd0);
    next(); flush = 1'b0; pc_valid = 1'b0; #2;
    chk("flush_idle_req", 64'(mem_req), 64'd0);
    chk("flush_idle_busy", 64'(busy), 64'd0);
    start_miss(64'h1000);
    serve_line(0, 64'h100C);

    // Flush during the second word, ack delayed three cycles
    start_miss(64'h2000);
    next(); pc_valid = 1'b0;
    wait_req(e, ok);
    if (ok) ack_word(e);
    wait_req(e, ok);
    next(); flush = 1'b1; #2;
    chk("abort_hold1", 64'(mem_req), 64'd1);
    next(); flush = 1'b0; #2;
    chk("abort_hold2", 64'(mem_req), 64'd1);
    chk("abort_addr", mem_addr, 64'h2004);
    next(); #2;
    chk("abort_hold3", 64'(mem_req), 64'd1);
    ack_word(e);
    chk("abort_req", 64'(mem_req), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    sb.delete();
    start_miss(64'h1000);
    serve_line(0, 64'h1004);

    // Asynchronous reset in the middle of a refill
    start_miss(64'h3000);
    next(); pc_valid = 1'b0;
    wait_req(e, ok);
    #1 rst_n = 1'b0;
    #1;
    chk("areset_req", 64'(mem_req), 64'd0);
    chk("areset_busy", 64'(busy), 64'd0);
    chk("areset_addr", mem_addr, 64'd0);
    next(); rst_n = 1'b1;
    sb.delete();
    start_miss(64'h1000);
    serve_line(0, 64'h1000);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
